// File: rtl/fetch_controller.sv
// fetch_controller
//   Single-outstanding instruction fetch sequencer. Issues one word-aligned
//   request to instruction memory, waits for the response, presents the
//   instruction downstream until it is consumed, then fetches the next word.
//   Redirects replace the fetch address. Any response already in flight is
//   discarded. A misaligned redirect target locks the block in FAULT until
//   reset.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   imem_req_valid    request valid (REQ state only)
//   imem_req_ready    memory accepts request this cycle
//   imem_addr         request address (pc while requesting, else 0)
//   imem_resp_valid   read data valid (ignored outside WAIT)
//   imem_rdata        read data
//   stall             downstream cannot take an instruction this cycle
//   redirect_valid    single-cycle redirect pulse
//   redirect_target   new fetch address
//   inst_valid        inst / inst_pc valid for downstream
//   inst, inst_pc     fetched instruction and its address
//   pc                next address to be fetched
//   fault             sticky misaligned-redirect flag
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | one cycle after reset, no outputs active
// REQ   | request driven at pc, waiting for imem_req_ready
// WAIT  | request accepted, waiting for imem_resp_valid
// HOLD  | instruction presented, held while stall is high
// FAULT | misaligned redirect seen, absorbing until reset

module fetch_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fault_q, fault_d;
  logic        kill_q, kill_d;

  logic redirect_bad;
  logic accept;

  assign redirect_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign accept       = (state_q == S_REQ) && imem_req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
      kill_q       <= kill_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fault_d      = fault_q;
    kill_d       = kill_q;

    // A misaligned target wins over everything else in every live state.
    if (state_q != S_FAULT && redirect_bad) begin
      state_d      = S_FAULT;
      fault_d      = 1'b1;
      inst_valid_d = 1'b0;
      kill_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redirect_valid) pc_d = redirect_target;
          state_d = S_REQ;
        end
        S_REQ: begin
          if (accept) begin
            inst_pc_d = pc_q;
            state_d   = S_WAIT;
            if (redirect_valid) begin
              // request already left at the old address: drop its response
              pc_d   = redirect_target;
              kill_d = 1'b1;
            end else begin
              pc_d   = pc_q + 32'd4;
              kill_d = 1'b0;
            end
          end else if (redirect_valid) begin
            pc_d = redirect_target;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_d = redirect_target;
            if (imem_resp_valid) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              kill_d = 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              inst_d       = imem_rdata;
              inst_valid_d = 1'b1;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            inst_valid_d = 1'b0;
            pc_d         = redirect_target;
            state_d      = S_REQ;
          end else if (!stall) begin
            inst_valid_d = 1'b0;
            state_d      = S_REQ;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_addr      = (state_q == S_REQ) ? pc_q : 32'h0;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_valid     = inst_valid_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller
//   Directed bench for fetch_controller. Inputs change and outputs are
//   sampled on the falling edge; every output of the DUT is registered or
//   state-derived, so the falling-edge sample reflects the last rising edge.

module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc;
  logic        fault;

  int total;
  int bad;

  fetch_controller #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .pc              (pc),
    .fault           (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Entered at a falling edge with the DUT in REQ at address a; returns at
  // the falling edge where the DUT is back in REQ at a+4.
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
    chk("req_valid", {31'h0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, a);
    imem_req_ready = 1'b1;
    cyc();
    chk("wait_req_valid", {31'h0, imem_req_valid}, 32'd0);
    chk("pc_inc", pc, a + 32'd4);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_rdata      = d;
    cyc();
    imem_resp_valid = 1'b0;
    stall           = 1'b0;
    chk("inst_valid", {31'h0, inst_valid}, 32'd1);
    chk("inst", inst, d);
    chk("inst_pc", inst_pc, a);
    cyc();
    chk("inst_valid_drop", {31'h0, inst_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_rdata      = 32'h0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;

    cyc();
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);

    reset = 1'b0;
    chk("idle_req_valid", {31'h0, imem_req_valid}, 32'd0);
    cyc();

    // back-to-back fetches, no stall
    fetch_one(32'h0000_0000, 32'h1111_0000);
    fetch_one(32'h0000_0004, 32'h2222_0004);
    fetch_one(32'h0000_0008, 32'h3333_0008);

    // stall in HOLD for 5 cycles
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'h4444_000C;
    cyc();
    imem_resp_valid = 1'b0;
    stall           = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_inst_valid", {31'h0, inst_valid}, 32'd1);
      chk("stall_inst", inst, 32'h4444_000C);
      chk("stall_inst_pc", inst_pc, 32'h0000_000C);
      chk("stall_no_req", {31'h0, imem_req_valid}, 32'd0);
    end
    stall = 1'b0;
    cyc();
    chk("unstall_inst_valid", {31'h0, inst_valid}, 32'd0);
    chk("unstall_req", {31'h0, imem_req_valid}, 32'd1);
    chk("unstall_addr", imem_addr, 32'h0000_0010);

    // ready low in REQ, redirect while waiting for accept
    cyc();
    chk("notready_addr", imem_addr, 32'h0000_0010);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    cyc();
    redirect_valid = 1'b0;
    chk("redir_req_addr", imem_addr, 32'h0000_0100);
    cyc();
    chk("redir_req_stable", imem_addr, 32'h0000_0100);
    fetch_one(32'h0000_0100, 32'h5555_0100);

    // redirect during WAIT: stale response dropped
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    cyc();
    redirect_valid = 1'b0;
    chk("wait_redir_pc", pc, 32'h0000_0040);
    chk("wait_redir_noreq", {31'h0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'hDEAD_0104;
    cyc();
    imem_resp_valid = 1'b0;
    chk("stale_dropped", {31'h0, inst_valid}, 32'd0);
    chk("after_kill_addr", imem_addr, 32'h0000_0040);
    fetch_one(32'h0000_0040, 32'h6666_0040);

    // redirect coincident with response
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0080;
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'hDEAD_0044;
    cyc();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    chk("coinc_inst_valid", {31'h0, inst_valid}, 32'd0);
    chk("coinc_req", {31'h0, imem_req_valid}, 32'd1);
    chk("coinc_addr", imem_addr, 32'h0000_0080);

    // redirect in HOLD while stalled: squash
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'h7777_0080;
    cyc();
    imem_resp_valid = 1'b0;
    chk("hold_inst_valid", {31'h0, inst_valid}, 32'd1);
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    cyc();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    chk("squash_inst_valid", {31'h0, inst_valid}, 32'd0);
    chk("squash_addr", imem_addr, 32'h0000_0200);
    chk("squash_req", {31'h0, imem_req_valid}, 32'd1);

    // redirect in the same cycle the request is accepted
    imem_req_ready  = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0300;
    cyc();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("acc_redir_noreq", {31'h0, imem_req_valid}, 32'd0);
    chk("acc_redir_pc", pc, 32'h0000_0300);
    chk("acc_redir_inst_pc", inst_pc, 32'h0000_0200);
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'hDEAD_0200;
    cyc();
    imem_resp_valid = 1'b0;
    chk("acc_redir_drop", {31'h0, inst_valid}, 32'd0);
    chk("acc_redir_addr", imem_addr, 32'h0000_0300);

    // pc wrap, then async reset mid-WAIT
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst_before_rst", inst, 32'h7777_0080);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_inst", inst, 32'h0);
    chk("async_rst_inst_pc", inst_pc, 32'h0);
    chk("async_rst_inst_valid", {31'h0, inst_valid}, 32'd0);
    chk("async_rst_req_valid", {31'h0, imem_req_valid}, 32'd0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_fault", {31'h0, fault}, 32'd0);
    cyc();
    reset           = 1'b0;
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'hDEAD_FFFC;
    cyc();
    chk("post_rst_ignore", {31'h0, inst_valid}, 32'd0);
    chk("post_rst_req", {31'h0, imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0000_0000);
    cyc();
    imem_resp_valid = 1'b0;
    chk("req_resp_ignore", {31'h0, inst_valid}, 32'd0);
    fetch_one(32'h0000_0000, 32'h8888_0000);

    // misaligned redirect: fault, no more requests until reset
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0042;
    cyc();
    redirect_valid = 1'b0;
    chk("fault_set", {31'h0, fault}, 32'd1);
    chk("fault_noreq", {31'h0, imem_req_valid}, 32'd0);
    chk("fault_inst_valid", {31'h0, inst_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b1;
      imem_rdata      = 32'hBAD0_0000 + 32'(i);
      cyc();
      chk("fault_stuck_noreq", {31'h0, imem_req_valid}, 32'd0);
      chk("fault_stuck", {31'h0, fault}, 32'd1);
      chk("fault_stuck_inst_valid", {31'h0, inst_valid}, 32'd0);
    end
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("fault_rst_pc", pc, 32'h0);
    chk("fault_rst_fault", {31'h0, fault}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("restart_req", {31'h0, imem_req_valid}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: fetch address loaded on reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_req_valid  output  1  instruction-memory request valid.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_addr  output  32  request address, word aligned.
REQ-007 imem_resp_valid  input  1  read data valid.
REQ-008 imem_rdata  input  32  read data.
REQ-009 stall  input  1  downstream cannot accept an instruction this cycle.
REQ-010 redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-011 redirect_target  input  32  new fetch address.
REQ-012 inst_valid  output  1  inst and inst_pc valid for downstream.
REQ-013 inst  output  32  fetched instruction.
REQ-014 inst_pc  output  32  address of inst.
REQ-015 pc  output  32  next address to be fetched.
REQ-016 fault  output  1  misaligned redirect detected; sticky until reset.

Function
REQ-017 States: IDLE, REQ, WAIT, HOLD, FAULT; one request outstanding at most.
REQ-018 IDLE: all outputs inactive; unconditional transition to REQ on the next edge.
REQ-019 REQ: imem_req_valid=1, imem_addr=pc; on valid&ready -> WAIT, pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), request address captured as inst_pc.
REQ-020 While in REQ and not accepted, imem_addr SHALL hold stable, except when changed by redirect (REQ-025).
REQ-021 WAIT: imem_req_valid=0; on imem_resp_valid -> inst <= imem_rdata, inst_valid <= 1, -> HOLD.
REQ-022 HOLD: inst, inst_pc, inst_valid held while stall=1; when stall=0 the instruction is consumed that cycle: inst_valid <= 0, -> REQ.
REQ-023 Effective throughput: one instruction per 3 cycles minimum (REQ, WAIT with 1-cycle memory, HOLD); no fetch overlap.
REQ-024 imem_resp_valid outside WAIT SHALL be ignored.
REQ-025 Redirect in REQ, not accepted: pc <= redirect_target, stay REQ. Accepted in the same cycle: -> WAIT with kill flag set, pc <= redirect_target.
REQ-026 Redirect in WAIT: set kill flag, pc <= redirect_target; the returning response is discarded (inst_valid stays 0), kill cleared, -> REQ.
REQ-027 Redirect in HOLD: inst_valid <= 0 (instruction squashed regardless of stall), pc <= redirect_target, -> REQ.
REQ-028 Redirect coincident with imem_resp_valid in WAIT: response discarded, -> REQ at target.
REQ-029 Redirect in IDLE: pc <= redirect_target, -> REQ.
REQ-030 redirect_target[1:0]!=0 in any state: fault <= 1, -> FAULT; no further requests, inst_valid <= 0; outstanding response ignored.
REQ-031 FAULT: absorbing; only reset exits.

Reset
REQ-032 Asserting reset at any time, including mid-request, SHALL immediately force: state IDLE, pc=RESET_VECTOR, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, fault=0, kill=0.
REQ-033 A memory response arriving after reset release for a pre-reset request is ignored (handled by REQ-024).

Verification
REQ-034 Reset release, ready=1, 1-cycle response, stall=0 -> addresses 0x0, 0x4, 0x8 issued; inst_pc matches each; inst_valid one cycle each.
REQ-035 stall=1 for 5 cycles in HOLD -> inst/inst_pc unchanged, no new request until stall falls.
REQ-036 ready=0 for 3 cycles in REQ with addr 0x8 -> imem_addr stable at 0x8; redirect to 0x100 in cycle 2 -> next accepted address 0x100.
REQ-037 Redirect to 0x40 during WAIT -> stale response dropped, next request 0x40, next inst_pc 0x40.
REQ-038 Redirect to 0x42 -> fault=1, imem_req_valid stays 0 until reset; reset returns pc to RESET_VECTOR, fault=0.
REQ-039 pc=32'hFFFF_FFFC accepted -> pc becomes 0x0; reset asserted mid-WAIT -> all outputs cleared asynchronously.
